seq_shift_add_mult: RTL and testbench
=====================================

Name: seq_shift_add_mult

Overview:
- Iterative shift-and-add multiplier. It replaces the opcode-sequenced multiply, which needed B<<1, C>>1, AND-LSB, add and 2's-complement steps issued one at a time by the controller.
- Operand width is parametrised, with a runtime signed/unsigned mode and a start/done handshake.
- Sits beside the ALU datapath. The controller loads two operands, pulses start and collects a 2*WIDTH-bit product.

Parameters:
- WIDTH, 8, operand width in bits (legal range 2..32).
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  reset; synchronous, active-high.
- start  input  1  request; sampled only in IDLE.
- signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
- a  input  WIDTH  multiplicand; sampled with start.
- b  input  WIDTH  multiplier; sampled with start.
- busy  output  1  high from the cycle after start is accepted until done is asserted.
- done  output  1  one-cycle pulse; product valid in that cycle.
- product  output  2*WIDTH  result; held until the next accepted start.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset values: state=IDLE, busy=0, done=0, product=0, internal accumulator/counter=0.
- rst asserted mid-operation aborts the operation. Next cycle is IDLE with all outputs at their reset values. No done pulse is issued for the aborted operation.
- State IDLE:
  - On start=1, capture operands.
  - signed_mode=1: mcand=|a|, mplier=|b| (WIDTH-bit unsigned magnitudes), neg=a[MSB]^b[MSB].
  - signed_mode=0: mcand=a, mplier=b, neg=0.
  - Clear acc (2*WIDTH), set cnt=0, go to RUN. busy=1 from the next cycle.
- Magnitude of the most-negative value (e.g. -128 at WIDTH=8) is 2^(WIDTH-1). This fits unsigned in WIDTH bits, so no overflow occurs.
- State RUN, one iteration per cycle:
  - If mplier[0]: acc += mcand zero-extended to 2*WIDTH.
  - Then mcand <<= 1 (held at 2*WIDTH bits) and mplier >>= 1 (logical); cnt++.
  - After exactly WIDTH iterations (cnt==WIDTH-1 on the last), go to SIGN.
  - No early termination. Latency is fixed regardless of operand values.
- State SIGN, one cycle:
  - product <= neg ? (~acc + 1) : acc. This is 2*WIDTH-bit two's complement.
  - Go to DONE.
- State DONE, one cycle:
  - done=1, busy=0, go to IDLE.
  - product remains stable in DONE and stays stable afterwards until a new start is accepted.
- Latency: start sampled high at edge N. done is high in the cycle following edge N+WIDTH+2. Throughput is one multiply per WIDTH+3 cycles.
- start while busy or in DONE is ignored. Requests are not queued.
- start held continuously high is accepted again in the first IDLE cycle after DONE.
- Operand inputs may change freely after the accept edge; they have no effect on the operation in flight.
- Zero operands need no special case: product=0, and neg is irrelevant because -0=0.
- Unsigned result max (2^WIDTH-1)^2 fits in 2*WIDTH bits.
- Signed results always fit 2*WIDTH bits. Extreme case: (-2^(WIDTH-1))^2 = 2^(2*WIDTH-2), which is positive and representable.
- Combinational paths from inputs to outputs are not permitted. All outputs are registered.

Test Plan:
- WIDTH=8, signed_mode=1, a=-8 (0xF8), b=-15 (0xF1), start 1 cycle -> busy high for 10 cycles, done pulse 11 cycles after the accept edge, product=0x0078 (120).
- signed_mode=1, a=-128 (0x80), b=127 (0x7F) -> product=0xC080 (-16256). Then a=0x80, b=0x80 -> product=0x4000 (16384).
- signed_mode=0, a=0xFF, b=0xFF -> product=0xFE01. Then a=5, b=14 -> 0x0046. Then a=0, b=0xAB -> 0x0000, with the same latency as non-zero operands.
- Accept a=3, b=4. Pulse start with a=9, b=9 at cycle 4 of RUN, and change a/b every cycle -> exactly one done, product=0x000C, no second operation started.
- Accept a=7, b=7. Assert rst for one cycle at cycle 5 -> next cycle busy=0, done=0, product=0, and no done pulse ever appears. Then a=2, b=-3 signed -> product=0xFFFA.
- Random regression at WIDTH=4, 8 and 13, both modes, start held high back-to-back -> each product matches the reference multiply, and done spacing is exactly WIDTH+3 cycles.

Source files
------------

// File: rtl/seq_shift_add_mult.sv
// Iterative shift-and-add multiplier with a start/done handshake.
// Signed operands are reduced to magnitudes up front, multiplied unsigned over
// WIDTH fixed iterations, and the sign is applied in a final two's-complement step.
module seq_shift_add_mult #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  typedef enum logic [1:0] {StIdle, StRun, StSign, StDone} state_e;

  localparam logic [WIDTH-1:0]   OneW    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] OneP    = {{(2*WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   CntOne  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   LastCnt = CNT_W'(WIDTH - 1);

  state_e               state_q, state_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 neg_q, neg_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  // Operand magnitudes; the most-negative value maps to 2^(WIDTH-1), which still fits.
  logic [WIDTH-1:0] mag_a, mag_b;

  // Magnitude conversion for the operands presented at the accept edge.
  always_comb begin
    mag_a = a;
    mag_b = b;
    if (signed_mode && a[WIDTH-1]) mag_a = ~a + OneW;
    if (signed_mode && b[WIDTH-1]) mag_b = ~b + OneW;
  end

  // Next-state and datapath update for the four-phase sequence.
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    product_d = product_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          mcand_d  = {{WIDTH{1'b0}}, mag_a};
          mplier_d = mag_b;
          neg_d    = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = StRun;
        end
      end
      StRun: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CntOne;
        // Fixed iteration count: no early exit, so latency never depends on data.
        if (cnt_q == LastCnt) state_d = StSign;
      end
      StSign: begin
        product_d = neg_q ? (~acc_q + OneP) : acc_q;
        state_d   = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Outputs are registered: busy tracks the non-idle phases, done follows DONE by a cycle.
    busy_d = (state_d != StIdle);
    done_d = (state_q == StDone);
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Scoreboard bench for seq_shift_add_mult at WIDTH 4, 8 and 13.
module tb_seq_shift_add_mult;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  int          n_checks = 0;
  int          n_fail = 0;
  bit          reg_go = 1'b0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, int unsigned w, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (w=%0d): got 0x%0h, expected 0x%0h", name, w, act, exp);
    end
  endfunction

  // Reference product, truncated to 2*w bits.
  function automatic logic [63:0] ref_mul(int unsigned w, bit s, logic [31:0] x, logic [31:0] y);
    longint mask, sx, sy, p;
    mask = (longint'(1) << w) - 1;
    sx = longint'(x) & mask;
    sy = longint'(y) & mask;
    if (s && x[w-1]) sx = sx - (longint'(1) << w);
    if (s && y[w-1]) sy = sy - (longint'(1) << w);
    p = sx * sy;
    return 64'(p) & ((64'd1 << (2 * w)) - 64'd1);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned W = (g == 0) ? 4 : ((g == 1) ? 8 : 13);

    logic           st = 1'b0;
    logic           sm = 1'b0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           busy;
    logic           done;
    logic [2*W-1:0] prod;
    logic [63:0]    q[$];
    bit             reg_active = 1'b0;
    bit             fin = 1'b0;
    int             done_cnt = 0;

    seq_shift_add_mult #(.WIDTH(W)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .start      (st),
      .signed_mode(sm),
      .a          (a),
      .b          (b),
      .busy       (busy),
      .done       (done),
      .product    (prod)
    );

    // Monitor: pop an expected product on every done pulse.
    initial begin : mon
      int unsigned last_cyc;
      bit          have_last;
      logic [63:0] e;
      last_cyc  = 0;
      have_last = 1'b0;
      forever begin
        @(negedge clk);
        if (!reg_active) have_last = 1'b0;
        if (done === 1'b1) begin
          done_cnt++;
          if (q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done (w=%0d): got done=1 with nothing pending, expected done=0", W);
          end else begin
            e = q.pop_front();
            check("product", W, 64'(prod), e);
          end
          if (reg_active) begin
            if (have_last) check("done_spacing", W, 64'(cyc - last_cyc), 64'(W + 3));
            last_cyc  = cyc;
            have_last = 1'b1;
          end
        end
      end
    end

    // Back-to-back operations with start held high; operands scrambled between accepts.
    task automatic regress();
      reg_active = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 16; i++) begin
        sm = (i >= 8);
        a  = W'($urandom);
        b  = W'($urandom);
        if (i == 0) begin
          a = '1;
          b = '1;
        end
        if (i == 8) begin
          a = {1'b1, {(W-1){1'b0}}};
          b = a;
        end
        q.push_back(ref_mul(W, sm, 32'(a), 32'(b)));
        st = 1'b1;
        for (int k = 1; k <= int'(W) + 3; k++) begin
          @(posedge clk);
          #1;
          if (k < int'(W) + 3) begin
            a  = W'($urandom);
            b  = W'($urandom);
            sm = ~sm;
          end
        end
      end
      st = 1'b0;
      repeat (W + 6) @(posedge clk);
      #1;
      check("queue_drained", W, 64'(q.size()), 64'd0);
      reg_active = 1'b0;
    endtask

    if (g == 1) begin : g_dir
      task automatic go(bit s, logic [W-1:0] x, logic [W-1:0] y, logic [63:0] e, bit push);
        @(posedge clk);
        #1;
        st = 1'b1;
        sm = s;
        a  = x;
        b  = y;
        if (push) q.push_back(e);
        @(posedge clk);
        #1;
        st = 1'b0;
      endtask

      // Counts sample points after the accept edge until done, bounded.
      task automatic wait_done(output int lat, output int nbusy);
        lat   = 0;
        nbusy = 0;
        do begin
          @(negedge clk);
          lat++;
          if (busy === 1'b1) nbusy++;
        end while (done !== 1'b1 && lat < 64);
      endtask

      initial begin
        int lat, nb, d0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", W, 64'(busy), 64'd0);
        check("reset_done", W, 64'(done), 64'd0);
        check("reset_product", W, 64'(prod), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        go(1'b1, 8'hF8, 8'hF1, 64'h0078, 1'b1);
        wait_done(lat, nb);
        check("latency", W, 64'(lat), 64'd11);
        check("busy_cycles", W, 64'(nb), 64'd10);

        go(1'b1, 8'h80, 8'h7F, 64'hC080, 1'b1);
        wait_done(lat, nb);
        go(1'b1, 8'h80, 8'h80, 64'h4000, 1'b1);
        wait_done(lat, nb);
        go(1'b0, 8'hFF, 8'hFF, 64'hFE01, 1'b1);
        wait_done(lat, nb);
        go(1'b0, 8'd5, 8'd14, 64'h0046, 1'b1);
        wait_done(lat, nb);
        go(1'b0, 8'd0, 8'hAB, 64'h0000, 1'b1);
        wait_done(lat, nb);
        check("latency_zero", W, 64'(lat), 64'd11);

        // A start pulse during RUN and noisy operands must not disturb the operation.
        d0 = done_cnt;
        go(1'b0, 8'd3, 8'd4, 64'h000C, 1'b1);
        for (int i = 1; i <= 14; i++) begin
          @(posedge clk);
          #1;
          st = (i == 3);
          a  = 8'($urandom);
          b  = 8'($urandom);
          if (i == 3) begin
            a = 8'd9;
            b = 8'd9;
          end
        end
        repeat (16) @(posedge clk);
        #1;
        check("ignored_start_dones", W, 64'(done_cnt - d0), 64'd1);

        // Abort mid-RUN with a one-cycle reset.
        d0 = done_cnt;
        go(1'b0, 8'd7, 8'd7, 64'h0, 1'b0);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_busy", W, 64'(busy), 64'd0);
        check("abort_done", W, 64'(done), 64'd0);
        check("abort_product", W, 64'(prod), 64'd0);
        repeat (20) @(posedge clk);
        #1;
        check("abort_no_done", W, 64'(done_cnt - d0), 64'd0);

        go(1'b1, 8'h02, 8'hFD, 64'hFFFA, 1'b1);
        wait_done(lat, nb);
        check("latency_after_abort", W, 64'(lat), 64'd11);

        @(posedge clk);
        #1;
        reg_go = 1'b1;
        regress();
        fin = 1'b1;
      end
    end else begin : g_reg
      initial begin
        wait (reg_go);
        regress();
        fin = 1'b1;
      end
    end
  end

  initial begin
    wait (g_dut[0].fin && g_dut[1].fin && g_dut[2].fin);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by time %0t, expected all sequences finished", $time);
    $fatal(1, "timeout");
  end

endmodule
